// File: rtl/l2_port_arbiter_pkg.sv
// Shared types and constants for the L2 port arbiter.
package l2_arb_pkg;

  localparam int unsigned NB_MASTERS = 2;
  localparam int unsigned MST_JTAG   = 0;
  localparam int unsigned MST_SOC    = 1;

  typedef logic [0:0] mst_idx_t;

  typedef enum logic {
    ARB_RR   = 1'b0,
    ARB_PRIO = 1'b1
  } arb_mode_e;

  typedef struct packed {
    logic     valid;
    mst_idx_t idx;
  } resp_tag_t;

endpackage

// File: rtl/l2_port_arbiter_sel.sv
// Combinational 2-way winner selector for the L2 port arbiter.
module l2_arb_sel
  import l2_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic [0:0] last_i,
  input  logic       force_i,
  input  logic       mode_i,
  output logic [0:0] winner_o,
  output logic       any_req_o
);

  // Pick the winner from the request vector and the priority state.
  always_comb begin
    winner_o  = mst_idx_t'(MST_JTAG);
    any_req_o = |req_i;
    unique case (req_i)
      2'b01:   winner_o = mst_idx_t'(MST_JTAG);
      2'b10:   winner_o = mst_idx_t'(MST_SOC);
      2'b11: begin
        if (mode_i == ARB_PRIO) begin
          winner_o = force_i ? mst_idx_t'(MST_SOC) : mst_idx_t'(MST_JTAG);
        end else begin
          winner_o = ~last_i;
        end
      end
      default: winner_o = mst_idx_t'(MST_JTAG);
    endcase
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Two-master arbiter for the single L2 RAM slave port (JTAG lint + SoC).
// Build option: L2_ARB_JTAG_PRIO_EN selects fixed JTAG priority with a
// starvation bound for the SoC master instead of round-robin.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                m_req_i,
  input  logic [2*ADDR_WIDTH-1:0]   m_add_i,
  input  logic [1:0]                m_wen_i,
  input  logic [2*DATA_WIDTH/8-1:0] m_be_i,
  input  logic [2*DATA_WIDTH-1:0]   m_wdata_i,
  output logic [1:0]                m_gnt_o,
  output logic [1:0]                m_r_valid_o,
  output logic [DATA_WIDTH-1:0]     m_r_rdata_o,
  output logic                      s_req_o,
  output logic [ADDR_WIDTH-1:0]     s_add_o,
  output logic                      s_wen_o,
  output logic [DATA_WIDTH/8-1:0]   s_be_o,
  output logic [DATA_WIDTH-1:0]     s_wdata_o,
  input  logic                      s_gnt_i,
  input  logic                      s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]     s_r_rdata_i
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  mst_idx_t  winner;
  logic      handshake;
  resp_tag_t tag_q, tag_d;

`ifdef L2_ARB_JTAG_PRIO_EN
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             force_soc;

  assign force_soc = (wait_cnt_q == CNT_W'(MAX_WAIT));

  l2_arb_sel u_sel (
    .req_i     (m_req_i),
    .last_i    (1'b0),
    .force_i   (force_soc),
    .mode_i    (ARB_PRIO),
    .winner_o  (winner),
    .any_req_o (s_req_o)
  );

  // Saturating count of cycles the SoC master has waited for a grant.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!m_req_i[MST_SOC] || m_gnt_o[MST_SOC]) begin
      wait_cnt_d = '0;
    end else if (!force_soc) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`else
  mst_idx_t ptr_q, ptr_d;

  l2_arb_sel u_sel (
    .req_i     (m_req_i),
    .last_i    (ptr_q),
    .force_i   (1'b0),
    .mode_i    (ARB_RR),
    .winner_o  (winner),
    .any_req_o (s_req_o)
  );

  // Last-granted pointer moves only on a completed handshake.
  always_comb begin
    ptr_d = handshake ? winner : ptr_q;
  end

  // Pointer register; reset to SoC so JTAG wins the first contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= mst_idx_t'(MST_SOC);
    else       ptr_q <= ptr_d;
  end
`endif

  assign handshake = s_req_o & s_gnt_i;

  // Request field mux toward L2 from the current winner.
  always_comb begin
    s_add_o   = winner[0] ? m_add_i[ADDR_WIDTH +: ADDR_WIDTH]   : m_add_i[0 +: ADDR_WIDTH];
    s_wen_o   = winner[0] ? m_wen_i[1]                          : m_wen_i[0];
    s_be_o    = winner[0] ? m_be_i[BE_W +: BE_W]                : m_be_i[0 +: BE_W];
    s_wdata_o = winner[0] ? m_wdata_i[DATA_WIDTH +: DATA_WIDTH] : m_wdata_i[0 +: DATA_WIDTH];
  end

  // Grant goes only to the winner, and only when someone is requesting.
  always_comb begin
    m_gnt_o         = '0;
    m_gnt_o[winner] = handshake;
  end

  // Tag is a one-deep pipeline: loaded per handshake, cleared otherwise.
  always_comb begin
    tag_d = '0;
    if (handshake) begin
      tag_d.valid = 1'b1;
      tag_d.idx   = winner;
    end
  end

  // Response tag register.
  always_ff @(posedge clk_i) begin
    if (rst_i) tag_q <= '0;
    else       tag_q <= tag_d;
  end

  // Route the L2 response to the tagged master; drop untagged or in-reset responses.
  always_comb begin
    m_r_valid_o = '0;
    if (tag_q.valid && s_r_valid_i && !rst_i) begin
      m_r_valid_o[tag_q.idx] = 1'b1;
    end
    m_r_rdata_o = s_r_rdata_i;
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed self-checking bench for l2_port_arbiter.
module tb_l2_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  m_req_i;
  logic [63:0] m_add_i;
  logic [1:0]  m_wen_i;
  logic [7:0]  m_be_i;
  logic [63:0] m_wdata_i;
  logic [1:0]  m_gnt_o;
  logic [1:0]  m_r_valid_o;
  logic [31:0] m_r_rdata_o;
  logic        s_req_o;
  logic [31:0] s_add_o;
  logic        s_wen_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_wdata_o;
  logic        s_gnt_i;
  logic        s_r_valid_i;
  logic [31:0] s_r_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_port_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MAX_WAIT   (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .m_req_i     (m_req_i),
    .m_add_i     (m_add_i),
    .m_wen_i     (m_wen_i),
    .m_be_i      (m_be_i),
    .m_wdata_i   (m_wdata_i),
    .m_gnt_o     (m_gnt_o),
    .m_r_valid_o (m_r_valid_o),
    .m_r_rdata_o (m_r_rdata_o),
    .s_req_o     (s_req_o),
    .s_add_o     (s_add_o),
    .s_wen_o     (s_wen_o),
    .s_be_o      (s_be_o),
    .s_wdata_o   (s_wdata_o),
    .s_gnt_i     (s_gnt_i),
    .s_r_valid_i (s_r_valid_i),
    .s_r_rdata_i (s_r_rdata_i)
  );

  task automatic idle_inputs();
    m_req_i     = 2'b00;
    m_add_i     = {32'h0000_0200, 32'h0000_0100};
    m_wen_i     = 2'b11;
    m_be_i      = 8'hFF;
    m_wdata_i   = '0;
    s_gnt_i     = 1'b0;
    s_r_valid_i = 1'b0;
    s_r_rdata_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i       = 1'b1;
    s_r_valid_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (m_r_valid_o !== 2'b00) begin
      errors++; $display("FAIL reset_rvalid: got %b expected 00", m_r_valid_o);
    end
    checks++;
    if (m_gnt_o !== 2'b00 || s_req_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle: gnt %b req %b expected 00 0", m_gnt_o, s_req_o);
    end
    @(negedge clk);
    rst_i       = 1'b0;
    s_r_valid_i = 1'b0;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    m_req_i   = 2'b01;
    m_add_i   = {32'h0000_0200, 32'h0000_0010};
    m_wen_i   = 2'b10;
    m_be_i    = 8'h0F;
    m_wdata_i = {32'h1111_2222, 32'hDEAD_BEEF};
    s_gnt_i   = 1'b1;
    #1;
    checks++;
    if (m_gnt_o !== 2'b01) begin
      errors++; $display("FAIL single_gnt: got %b expected 01", m_gnt_o);
    end
    checks++;
    if (s_req_o !== 1'b1 || s_add_o !== 32'h10 || s_wen_o !== 1'b0 ||
        s_be_o !== 4'hF || s_wdata_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_fields: req %b add %h wen %b be %h wdata %h expected 1 10 0 f deadbeef",
               s_req_o, s_add_o, s_wen_o, s_be_o, s_wdata_o);
    end
    @(negedge clk);
    idle_inputs();
    s_gnt_i     = 1'b1;
    s_r_valid_i = 1'b1;
    #1;
    checks++;
    if (m_r_valid_o !== 2'b01 || m_gnt_o !== 2'b00) begin
      errors++; $display("FAIL single_resp: rvalid %b gnt %b expected 01 00", m_r_valid_o, m_gnt_o);
    end
    @(negedge clk);
    s_r_valid_i = 1'b0;
    #1;
    checks++;
    if (m_r_valid_o !== 2'b00) begin
      errors++; $display("FAIL single_after: got %b expected 00", m_r_valid_o);
    end
  endtask

`ifndef L2_ARB_JTAG_PRIO_EN
  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    logic [1:0] prev_gnt;
    prev_gnt = 2'b00;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      m_req_i     = 2'b11;
      s_gnt_i     = 1'b1;
      s_r_valid_i = (k > 0);
      s_r_rdata_i = 32'hA000_0000 + 32'(k);
      #1;
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (m_gnt_o !== exp_gnt) begin
        errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, m_gnt_o, exp_gnt);
      end
      checks++;
      if (s_add_o !== ((k % 2 == 0) ? 32'h100 : 32'h200)) begin
        errors++; $display("FAIL rr_add[%0d]: got %h", k, s_add_o);
      end
      if (k > 0) begin
        checks++;
        if (m_r_valid_o !== prev_gnt || m_r_rdata_o !== 32'hA000_0000 + 32'(k)) begin
          errors++;
          $display("FAIL rr_resp[%0d]: rvalid %b rdata %h expected %b %h",
                   k, m_r_valid_o, m_r_rdata_o, prev_gnt, 32'hA000_0000 + 32'(k));
        end
      end
      prev_gnt = exp_gnt;
    end
    @(negedge clk);
    m_req_i     = 2'b00;
    s_gnt_i     = 1'b0;
    s_r_valid_i = 1'b1;
    #1;
    checks++;
    if (m_r_valid_o !== 2'b10) begin
      errors++; $display("FAIL rr_tail: got %b expected 10", m_r_valid_o);
    end
  endtask

  task automatic test_gnt_low();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m_req_i     = 2'b11;
      s_gnt_i     = 1'b0;
      s_r_valid_i = 1'b1;
      #1;
      checks++;
      if (m_gnt_o !== 2'b00 || m_r_valid_o !== 2'b00 || s_req_o !== 1'b1 || s_add_o !== 32'h100) begin
        errors++;
        $display("FAIL gntlow[%0d]: gnt %b rvalid %b req %b add %h expected 00 00 1 100",
                 k, m_gnt_o, m_r_valid_o, s_req_o, s_add_o);
      end
    end
    @(negedge clk);
    s_gnt_i     = 1'b1;
    s_r_valid_i = 1'b0;
    #1;
    checks++;
    if (m_gnt_o !== 2'b01) begin
      errors++; $display("FAIL gntlow_release: got %b expected 01", m_gnt_o);
    end
    @(negedge clk);
    m_req_i     = 2'b00;
    s_r_valid_i = 1'b1;
    #1;
    checks++;
    if (m_r_valid_o !== 2'b01) begin
      errors++; $display("FAIL gntlow_resp: got %b expected 01", m_r_valid_o);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    idle_inputs();
    m_req_i = 2'b01;
    s_gnt_i = 1'b1;
    #1;
    checks++;
    if (m_gnt_o !== 2'b01) begin
      errors++; $display("FAIL midrst_gnt: got %b expected 01", m_gnt_o);
    end
    @(negedge clk);
    rst_i       = 1'b1;
    m_req_i     = 2'b00;
    s_r_valid_i = 1'b1;
    #1;
    checks++;
    if (m_r_valid_o !== 2'b00) begin
      errors++; $display("FAIL midrst_drop: got %b expected 00", m_r_valid_o);
    end
    @(negedge clk);
    rst_i   = 1'b0;
    m_req_i = 2'b11;
    #1;
    checks++;
    if (m_r_valid_o !== 2'b00) begin
      errors++; $display("FAIL midrst_after: got %b expected 00", m_r_valid_o);
    end
    checks++;
    if (m_gnt_o !== 2'b01) begin
      errors++; $display("FAIL midrst_ptr: got %b expected 01", m_gnt_o);
    end
    @(negedge clk);
    m_req_i = 2'b00;
    #1;
    checks++;
    if (m_r_valid_o !== 2'b01) begin
      errors++; $display("FAIL midrst_resp: got %b expected 01", m_r_valid_o);
    end
  endtask
`else
  task automatic test_jtag_prio();
    logic [1:0] exp_gnt;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      m_req_i = 2'b11;
      s_gnt_i = 1'b1;
      #1;
      exp_gnt = (k % 5 == 4) ? 2'b10 : 2'b01;
      checks++;
      if (m_gnt_o !== exp_gnt) begin
        errors++; $display("FAIL prio_gnt[%0d]: got %b expected %b", k, m_gnt_o, exp_gnt);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask
`endif

  task automatic test_spurious();
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    s_r_valid_i = 1'b1;
    s_r_rdata_i = 32'h5555_AAAA;
    #1;
    checks++;
    if (m_r_valid_o !== 2'b00) begin
      errors++; $display("FAIL spurious: got %b expected 00", m_r_valid_o);
    end
    @(negedge clk);
    s_r_valid_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    test_reset();
    test_single_write();
`ifndef L2_ARB_JTAG_PRIO_EN
    test_round_robin();
    test_gnt_low();
    test_reset_midflight();
`else
    test_jtag_prio();
`endif
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
